// File: rtl/pp_accum_pkg.sv
// Shared widths, group limit and FSM state encodings for the partial-product
// accumulator and its sign-magnitude converter.
package pp_accum_pkg;

   localparam int MAG_W     = 14;
   localparam int ACC_W     = 18;
   localparam int MAX_TERMS = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   typedef struct packed {
      logic truncated;
      logic exp_mismatch;
   } flags_t;

endpackage

// File: rtl/pp_accum_sm2tc.sv
// Sign-magnitude to two's-complement conversion of one aligned partial product,
// zero-extended then negated when the sign is set, so -0 maps to 0.
module sm2tc #(
   parameter int MAG_W = 14,
   parameter int ACC_W = 18
) (
   input  logic             sign,
   input  logic [MAG_W-1:0] mag,
   output logic [ACC_W-1:0] term,
   output logic [50:0]      number
);

   logic [ACC_W-1:0] mag_ext;

   assign mag_ext = {{(ACC_W-MAG_W){1'b0}}, mag};
   assign term    = sign ? (~mag_ext + 1'b1) : mag_ext;

   // Static cost: one negating adder bit per accumulator bit plus one mux per magnitude bit.
   assign number  = 51'(MAG_W + ACC_W);

endmodule

// File: rtl/pp_accum.sv
// Groups signed aligned partial products into sums of up to MAX_TERMS terms and
// presents each group result with a valid/ready handshake.
module pp_accum #(
   parameter int MAG_W     = pp_accum_pkg::MAG_W,
   parameter int ACC_W     = pp_accum_pkg::ACC_W,
   parameter int MAX_TERMS = pp_accum_pkg::MAX_TERMS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             pp_sign,
   input  logic [MAG_W-1:0] shifted_unsign_pp,
   input  logic [5:0]       max_exp,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [5:0]       out_exp,
   output logic [3:0]       out_cnt,
   output logic [1:0]       out_flags,
   output logic [50:0]      number
);

   import pp_accum_pkg::*;

   localparam logic [3:0] MAX_CNT = 4'(MAX_TERMS);

   logic [1:0]       state_reg;
   logic [ACC_W-1:0] acc_reg;
   logic [3:0]       cnt_reg;
   logic [5:0]       exp_reg;
   flags_t           flags_reg;

   logic [ACC_W-1:0] term;
   logic [3:0]       cnt_next;
   logic             accept;
   logic             full_first;
   logic             full_next;

   sm2tc #(
      .MAG_W (MAG_W),
      .ACC_W (ACC_W)
   ) u_sm2tc (
      .sign   (pp_sign),
      .mag    (shifted_unsign_pp),
      .term   (term),
      .number (number)
   );

   assign accept     = in_valid && in_ready;
   assign cnt_next   = cnt_reg + 4'd1;
   assign full_first = (MAX_CNT == 4'd1);
   assign full_next  = (cnt_next == MAX_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         exp_reg   <= '0;
         flags_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  acc_reg                <= term;
                  cnt_reg                <= 4'd1;
                  exp_reg                <= max_exp;
                  flags_reg.exp_mismatch <= 1'b0;
                  flags_reg.truncated    <= full_first && !in_last;
                  state_reg              <= (in_last || full_first) ? ST_HOLD : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (accept) begin
                  acc_reg <= acc_reg + term;
                  cnt_reg <= cnt_next;
                  // Both flags are sticky for the remainder of the group.
                  if (max_exp != exp_reg) flags_reg.exp_mismatch <= 1'b1;
                  if (full_next && !in_last) flags_reg.truncated <= 1'b1;
                  if (in_last || full_next) state_reg <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Outputs come straight from the group registers; they are frozen in HOLD.
   assign in_ready  = (state_reg != ST_HOLD);
   assign out_valid = (state_reg == ST_HOLD);
   assign out_sum   = acc_reg;
   assign out_exp   = exp_reg;
   assign out_cnt   = cnt_reg;
   assign out_flags = flags_reg;

endmodule

// File: tb/tb_pp_accum.sv
// Self-checking bench for pp_accum: directed vector table, hold/reset sequences
// and a randomized run against a queue-based group model.
module tb_pp_accum;

   localparam int MAG_W     = 14;
   localparam int ACC_W     = 18;
   localparam int MAX_TERMS = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             pp_sign = 1'b0;
   logic [MAG_W-1:0] shifted_unsign_pp = '0;
   logic [5:0]       max_exp = '0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_sum;
   logic [5:0]       out_exp;
   logic [3:0]       out_cnt;
   logic [1:0]       out_flags;
   logic [50:0]      number;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   pp_accum #(
      .MAG_W     (MAG_W),
      .ACC_W     (ACC_W),
      .MAX_TERMS (MAX_TERMS)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .pp_sign           (pp_sign),
      .shifted_unsign_pp (shifted_unsign_pp),
      .max_exp           (max_exp),
      .in_last           (in_last),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_sum           (out_sum),
      .out_exp           (out_exp),
      .out_cnt           (out_cnt),
      .out_flags         (out_flags),
      .number            (number)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input bit s, input logic [MAG_W-1:0] m, input logic [5:0] e, input bit l);
      int waited = 0;
      @(negedge clk);
      pp_sign = s; shifted_unsign_pp = m; max_exp = e; in_last = l; in_valid = 1'b1;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("send_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
      $display("term sign=%0d mag=%0h exp=%0d last=%0d", s, m, e, l);
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release_valid", 64'(out_valid), 64'd0);
      check("release_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_sum"},   64'(out_sum), 64'd0);
      check({tag, "_exp"},   64'(out_exp), 64'd0);
      check({tag, "_cnt"},   64'(out_cnt), 64'd0);
      check({tag, "_flags"}, 64'(out_flags), 64'd0);
   endtask

   typedef struct {
      bit               sign;
      logic [MAG_W-1:0] mag;
      logic [5:0]       mexp;
      bit               last;
      bit               closes;
      logic [ACC_W-1:0] sum;
      logic [5:0]       oexp;
      logic [3:0]       cnt;
      logic [1:0]       flags;
   } vec_t;

   vec_t vecs[$];

   // Behavioural group model for the randomized run.
   int         m_terms[$];
   bit         m_hold;
   logic [5:0] m_exp;
   bit         m_mism;
   bit         m_trunc;

   function automatic logic [ACC_W-1:0] model_sum();
      longint s = 0;
      foreach (m_terms[i]) s += m_terms[i];
      return ACC_W'(s);
   endfunction

   initial begin
      // Reset state
      #12;
      check_idle_zero("reset");
      check("number", 64'(number), 64'(MAG_W + ACC_W));
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: single term, pos/neg pair, exp mismatch with -0, 8-term truncation, 9th term
      vecs.push_back('{0, 14'h3800, 6'd0, 1, 1, 18'd14336, 6'd0, 4'd1, 2'b00});
      vecs.push_back('{1, 14'h3800, 6'd9, 0, 0, '0, '0, '0, '0});
      vecs.push_back('{0, 14'h1C00, 6'd9, 1, 1, 18'h3E400, 6'd9, 4'd2, 2'b00});
      vecs.push_back('{0, 14'h0100, 6'd9, 0, 0, '0, '0, '0, '0});
      vecs.push_back('{1, 14'h0000, 6'd10, 1, 1, 18'h00100, 6'd9, 4'd2, 2'b01});
      for (int i = 0; i < 7; i++) vecs.push_back('{0, 14'h3800, 6'd3, 0, 0, '0, '0, '0, '0});
      vecs.push_back('{0, 14'h3800, 6'd3, 0, 1, 18'd114688, 6'd3, 4'd8, 2'b10});
      vecs.push_back('{1, 14'h3FFF, 6'd4, 1, 1, 18'h3C001, 6'd4, 4'd1, 2'b00});

      foreach (vecs[i]) begin
         send(vecs[i].sign, vecs[i].mag, vecs[i].mexp, vecs[i].last);
         check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].closes));
         if (vecs[i].closes) begin
            check($sformatf("vec%0d_sum", i),   64'(out_sum),   64'(vecs[i].sum));
            check($sformatf("vec%0d_exp", i),   64'(out_exp),   64'(vecs[i].oexp));
            check($sformatf("vec%0d_cnt", i),   64'(out_cnt),   64'(vecs[i].cnt));
            check($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].flags));
            check($sformatf("vec%0d_noready", i), 64'(in_ready), 64'd0);
            release_out();
         end else begin
            check($sformatf("vec%0d_ready", i), 64'(in_ready), 64'd1);
         end
      end

      // Stall in HOLD for 5 cycles while upstream keeps offering a term
      send(1'b0, 14'h0123, 6'd7, 1'b1);
      @(negedge clk);
      pp_sign = 1'b1; shifted_unsign_pp = 14'h0FFF; max_exp = 6'd2; in_last = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("hold_ready", 64'(in_ready), 64'd0);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_sum", 64'(out_sum), 64'h123);
         check("hold_cnt", 64'(out_cnt), 64'd1);
         check("hold_exp", 64'(out_exp), 64'd7);
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      release_out();
      $display("hold sequence done");

      // Reset after 3 accepted terms discards the group
      send(1'b0, 14'h1000, 6'd5, 1'b0);
      send(1'b0, 14'h1000, 6'd5, 1'b0);
      send(1'b1, 14'h0010, 6'd5, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_zero("midrst");
      @(negedge clk);
      check_idle_zero("midrst_hold");
      rst_n = 1'b1;
      send(1'b0, 14'h0005, 6'd1, 1'b1);
      check("postrst_valid", 64'(out_valid), 64'd1);
      check("postrst_sum", 64'(out_sum), 64'd5);
      check("postrst_cnt", 64'(out_cnt), 64'd1);
      release_out();
      $display("reset sequence done");

      // Randomized run: inputs change at negedge, model steps at posedge
      m_hold = 0; m_terms.delete(); m_exp = '0; m_mism = 0; m_trunc = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         check("rnd_valid", 64'(out_valid), 64'(m_hold));
         check("rnd_ready", 64'(in_ready), 64'(!m_hold));
         if (m_hold) begin
            check("rnd_sum",   64'(out_sum),   64'(model_sum()));
            check("rnd_exp",   64'(out_exp),   64'(m_exp));
            check("rnd_cnt",   64'(out_cnt),   64'(m_terms.size()));
            check("rnd_flags", 64'(out_flags), 64'({m_trunc, m_mism}));
         end
         in_valid  = ($urandom_range(0, 9) < 7);
         pp_sign   = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       shifted_unsign_pp = '0;
            1:       shifted_unsign_pp = '1;
            default: shifted_unsign_pp = MAG_W'($urandom);
         endcase
         max_exp   = 6'($urandom_range(0, 3));
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = $urandom_range(0, 1);
         @(posedge clk);
         if (m_hold) begin
            if (out_ready) begin
               $display("group sum=%0h cnt=%0d exp=%0d flags=%0b", model_sum(), m_terms.size(), m_exp, {m_trunc, m_mism});
               m_hold = 0;
               m_terms.delete();
            end
         end else if (in_valid) begin
            if (m_terms.size() == 0) begin
               m_exp = max_exp; m_mism = 0; m_trunc = 0;
            end else if (max_exp != m_exp) begin
               m_mism = 1;
            end
            m_terms.push_back(pp_sign ? -int'(shifted_unsign_pp) : int'(shifted_unsign_pp));
            if (in_last || m_terms.size() == MAX_TERMS) begin
               m_hold  = 1;
               m_trunc = !in_last;
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
